// File: rtl/alu_seq_responder_pkg.sv
// Shared constants, opcodes and FSM state encoding for the sequential ALU responder.
// Optional overflow output is enabled by defining ALU_SEQ_OVF_EN.
package alu_seq_responder_pkg;

   localparam int DATA_INDEX_LIMIT     = 31;
   localparam int DATA_WIDTH           = DATA_INDEX_LIMIT + 1;
   localparam int ALU_OPRN_INDEX_LIMIT = 5;
   localparam int ALU_OPRN_WIDTH       = ALU_OPRN_INDEX_LIMIT + 1;
   localparam int MUL_CYCLES           = DATA_WIDTH;

   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_ADD = 6'h01;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_SUB = 6'h02;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_MUL = 6'h03;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_SHR = 6'h04;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_SHL = 6'h05;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_AND = 6'h06;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_OR  = 6'h07;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_NOR = 6'h08;
   localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OP_SLT = 6'h09;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   function automatic logic is_shift_op(input logic [ALU_OPRN_INDEX_LIMIT:0] op);
      return (op == ALU_OP_SHR) || (op == ALU_OP_SHL);
   endfunction

endpackage

// File: rtl/alu_seq_responder_if.sv
// Request/response handshake bundle between control unit (master) and ALU responder (slave).
// The ovf signal exists only when ALU_SEQ_OVF_EN is defined.
interface alu_seq_responder_if
   import alu_seq_responder_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int OW = ALU_OPRN_WIDTH
) ();

   logic          req_valid;
   logic          req_ready;
   logic [DW-1:0] op1;
   logic [DW-1:0] op2;
   logic [OW-1:0] oprn;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] out;
   logic          zero;
`ifdef ALU_SEQ_OVF_EN
   logic          ovf;
`endif

   modport master (
      output req_valid, op1, op2, oprn, rsp_ready,
`ifdef ALU_SEQ_OVF_EN
      input  ovf,
`endif
      input  req_ready, rsp_valid, out, zero
   );

   modport slave (
      input  req_valid, op1, op2, oprn, rsp_ready,
`ifdef ALU_SEQ_OVF_EN
      output ovf,
`endif
      output req_ready, rsp_valid, out, zero
   );

endinterface

// File: rtl/alu_seq_responder_mult.sv
// Iterative shift-add multiplier (module alu_seq_mult): one partial product per cycle after start.
// done marks the final iteration; product then carries the completed low DW bits.
module alu_seq_mult #(
   parameter int DW      = 32,
   parameter int MUL_CYC = DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          done,
   output logic [DW-1:0] product
);

   localparam int CW = $clog2(MUL_CYC + 1);

   logic          busy;
   logic [CW-1:0] cnt;
   logic [DW-1:0] acc;
   logic [DW-1:0] mcand;
   logic [DW-1:0] mplier;

   // product is the accumulator including this cycle's partial product
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= CW'(MUL_CYC);
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_responder.sv
// Sequential handshaked ALU: single-cycle logic/arith ops, iterative mul and bit-serial shifts.
// Define ALU_SEQ_OVF_EN to add the signed add/sub overflow output.
//
// state | meaning
// IDLE  | ready for a request; operands latched on handshake
// EXEC  | iterating mul or shift, counter counting down to terminal count
// DONE  | response held on out/zero until rsp_ready
module alu_seq_responder
   import alu_seq_responder_pkg::*;
#(
   parameter int DW      = DATA_WIDTH,
   parameter int OW      = ALU_OPRN_WIDTH,
   parameter int MUL_CYC = MUL_CYCLES
) (
   input logic                clk,
   input logic                rst,
   alu_seq_responder_if.slave bus
);

   localparam int CW = $clog2(((DW > MUL_CYC) ? DW : MUL_CYC) + 1);

   alu_state_t    state;
   logic          req_ready_q;
   logic          rsp_valid_q;
   logic [DW-1:0] out_q;
   logic          zero_q;
   logic [CW-1:0] cnt;
   logic [OW-1:0] op_q;
   logic [DW-1:0] work;

   logic          accept;
   logic          is_mul;
   logic          needs_exec;
   logic [CW-1:0] shamt_c;
   logic [DW-1:0] sum_c;
   logic [DW-1:0] dif_c;
   logic [DW-1:0] res_c;
   logic [DW-1:0] work_shift;
   logic [DW-1:0] exec_res;
   logic          exec_last;
   logic          mult_start;
   logic          mult_done;
   logic [DW-1:0] mult_product;

   assign accept     = req_ready_q && bus.req_valid;
   assign is_mul     = (bus.oprn == ALU_OP_MUL);
   assign mult_start = accept && is_mul;

   // shift amounts of DW or more saturate to DW, which clears the word
   assign shamt_c    = (bus.op2 >= DW'(DW)) ? CW'(DW) : bus.op2[CW-1:0];
   assign needs_exec = is_mul || (is_shift_op(bus.oprn) && (shamt_c != '0));

   assign sum_c = bus.op1 + bus.op2;
   assign dif_c = bus.op1 - bus.op2;

   always_comb begin
      res_c = '0;
      case (bus.oprn)
         ALU_OP_ADD: res_c = sum_c;
         ALU_OP_SUB: res_c = dif_c;
         ALU_OP_SHR: res_c = bus.op1;
         ALU_OP_SHL: res_c = bus.op1;
         ALU_OP_AND: res_c = bus.op1 & bus.op2;
         ALU_OP_OR:  res_c = bus.op1 | bus.op2;
         ALU_OP_NOR: res_c = ~(bus.op1 | bus.op2);
         ALU_OP_SLT: res_c = {{(DW-1){1'b0}}, (bus.op1 < bus.op2)};
         default:    res_c = '0;
      endcase
   end

   assign work_shift = (op_q == ALU_OP_SHR) ? (work >> 1) : (work << 1);
   assign exec_res   = (op_q == ALU_OP_MUL) ? mult_product : work_shift;
   assign exec_last  = (op_q == ALU_OP_MUL) ? mult_done : (cnt == CW'(1));

   alu_seq_mult #(
      .DW      (DW),
      .MUL_CYC (MUL_CYC)
   ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (mult_start),
      .a       (bus.op1),
      .b       (bus.op2),
      .done    (mult_done),
      .product (mult_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         out_q       <= '0;
         zero_q      <= 1'b1;
         cnt         <= '0;
         op_q        <= '0;
         work        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  op_q        <= bus.oprn;
                  work        <= bus.op1;
                  req_ready_q <= 1'b0;
                  if (needs_exec) begin
                     cnt   <= is_mul ? CW'(MUL_CYC) : shamt_c;
                     state <= ST_EXEC;
                  end else begin
                     out_q       <= res_c;
                     zero_q      <= (res_c == '0);
                     rsp_valid_q <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_EXEC: begin
               cnt  <= cnt - CW'(1);
               work <= work_shift;
               if (exec_last) begin
                  out_q       <= exec_res;
                  zero_q      <= (exec_res == '0);
                  rsp_valid_q <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.out       = out_q;
   assign bus.zero      = zero_q;

`ifdef ALU_SEQ_OVF_EN
   logic ovf_c;
   logic ovf_q;

   // operands agree in sign (op2 negated for sub) but the result sign flips
   always_comb begin
      ovf_c = 1'b0;
      if (bus.oprn == ALU_OP_ADD) begin
         ovf_c = (bus.op1[DW-1] == bus.op2[DW-1]) && (sum_c[DW-1] != bus.op1[DW-1]);
      end else if (bus.oprn == ALU_OP_SUB) begin
         ovf_c = (bus.op1[DW-1] != bus.op2[DW-1]) && (dif_c[DW-1] != bus.op1[DW-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= ovf_c;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_responder.sv
// Scoreboard bench for alu_seq_responder: driver pushes expected responses, monitor pops and checks.
// Checks ovf as well when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq_responder;
   import alu_seq_responder_pkg::*;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] out;
      logic        zero;
      int          lat;
      logic        ovf;
      int          hold;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] out;
      logic        zero;
      int          lat;
      logic        ovf;
      int          hold;
      int          hs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_rsp_hs = -100;

   exp_t sb[$];
   vec_t vecs[$];

   logic        in_rsp = 1'b0;
   int          hold_left = 0;
   logic [31:0] held_out;
   logic        held_zero;
   exp_t        mon_e;

   alu_seq_responder_if #(.DW(32), .OW(6)) bus ();

   alu_seq_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic add_vec(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] out, input logic zero,
                          input int lat, input logic ovf, input int hold);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.out = out;
      v.zero = zero; v.lat = lat; v.ovf = ovf; v.hold = hold;
      vecs.push_back(v);
   endtask

   // monitor and consumer: checks each response on its first valid cycle, then applies backpressure
   always @(negedge clk) begin
      if (rst) begin
         in_rsp = 1'b0;
         bus.rsp_ready = 1'b0;
      end else if (bus.rsp_valid) begin
         if (!in_rsp) begin
            in_rsp = 1'b1;
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
               hold_left = 0;
            end else begin
               mon_e = sb.pop_front();
               chk({mon_e.name, "_out"}, bus.out, mon_e.out);
               chk({mon_e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, mon_e.zero});
               chk({mon_e.name, "_lat"}, cyc - mon_e.hs + 1, mon_e.lat);
`ifdef ALU_SEQ_OVF_EN
               chk({mon_e.name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, mon_e.ovf});
`endif
               hold_left = mon_e.hold;
            end
            held_out  = bus.out;
            held_zero = bus.zero;
         end else begin
            chk("bp_out_stable", bus.out, held_out);
            chk("bp_zero_stable", {31'd0, bus.zero}, {31'd0, held_zero});
            chk("bp_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
         end
         if (hold_left > 0) begin
            bus.rsp_ready = 1'b0;
            hold_left--;
         end else begin
            bus.rsp_ready = 1'b1;
            last_rsp_hs = cyc + 1;
         end
      end else begin
         in_rsp = 1'b0;
         bus.rsp_ready = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic hs_ok;
      logic drained;
      exp_t e;

      bus.req_valid = 1'b0;
      bus.op1       = '0;
      bus.op2       = '0;
      bus.oprn      = '0;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_out", bus.out, 32'd0);
      chk("rst_zero", {31'd0, bus.zero}, 32'd1);
      rst = 1'b0;

      add_vec("add_15_3",   ALU_OP_ADD, 32'd15,        32'd3,         32'd18,        1'b0, 1,  1'b0, 0);
      add_vec("sub_5_5",    ALU_OP_SUB, 32'd5,         32'd5,         32'd0,         1'b1, 1,  1'b0, 0);
      add_vec("add_ovf",    ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1,  1'b1, 0);
      add_vec("sub_ovf",    ALU_OP_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1,  1'b1, 0);
      add_vec("mul_7_5",    ALU_OP_MUL, 32'd7,         32'd5,         32'd35,        1'b0, 33, 1'b0, 0);
      add_vec("mul_neg",    ALU_OP_MUL, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'd35,        1'b0, 33, 1'b0, 0);
      add_vec("mul_0_5",    ALU_OP_MUL, 32'd0,         32'd5,         32'd0,         1'b1, 33, 1'b0, 0);
      add_vec("shr_31_2",   ALU_OP_SHR, 32'd31,        32'd2,         32'd7,         1'b0, 3,  1'b0, 0);
      add_vec("shl_1_5",    ALU_OP_SHL, 32'd1,         32'd5,         32'd32,        1'b0, 6,  1'b0, 0);
      add_vec("shl_1_0",    ALU_OP_SHL, 32'd1,         32'd0,         32'd1,         1'b0, 1,  1'b0, 0);
      add_vec("shl_1_40",   ALU_OP_SHL, 32'd1,         32'd40,        32'd0,         1'b1, 33, 1'b0, 0);
      add_vec("shr_msb_31", ALU_OP_SHR, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 32, 1'b0, 0);
      add_vec("shr_all_32", ALU_OP_SHR, 32'hFFFF_FFFF, 32'd32,        32'd0,         1'b1, 33, 1'b0, 0);
      add_vec("and_11_4",   ALU_OP_AND, 32'd11,        32'd4,         32'd0,         1'b1, 1,  1'b0, 0);
      add_vec("nor_m8_2",   ALU_OP_NOR, 32'hFFFF_FFF8, 32'd2,         32'd5,         1'b0, 1,  1'b0, 0);
      add_vec("slt_11_15",  ALU_OP_SLT, 32'd11,        32'd15,        32'd1,         1'b0, 1,  1'b0, 0);
      add_vec("slt_11_11",  ALU_OP_SLT, 32'd11,        32'd11,        32'd0,         1'b1, 1,  1'b0, 0);
      add_vec("bad_op_0f",  6'h0F,      32'd123,       32'd4,         32'd0,         1'b1, 1,  1'b0, 0);
      add_vec("or_8_3_bp",  ALU_OP_OR,  32'd8,         32'd3,         32'd11,        1'b0, 1,  1'b0, 5);
      add_vec("sub_after",  ALU_OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1,  1'b0, 0);
      add_vec("mul_bp",     ALU_OP_MUL, 32'd9,         32'd9,         32'd81,        1'b0, 33, 1'b0, 5);
      add_vec("or_last",    ALU_OP_OR,  32'd8,         32'd3,         32'd11,        1'b0, 1,  1'b0, 0);

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         bus.oprn      = vecs[i].op;
         bus.op1       = vecs[i].a;
         bus.op2       = vecs[i].b;
         bus.req_valid = 1'b1;
         hs_ok = 1'b0;
         for (int w = 0; w < 200 && !hs_ok; w++) begin
            @(negedge clk);
            if (bus.req_ready) begin
               @(posedge clk);
               #1;
               hs_ok = 1'b1;
            end
         end
         bus.req_valid = 1'b0;
         if (!hs_ok) begin
            chk({vecs[i].name, "_hs_timeout"}, 32'd0, 32'd1);
         end else begin
            if (i > 0) chk({vecs[i].name, "_accept_gap"}, cyc, last_rsp_hs + 1);
            e.name = vecs[i].name; e.out = vecs[i].out; e.zero = vecs[i].zero;
            e.lat = vecs[i].lat; e.ovf = vecs[i].ovf; e.hold = vecs[i].hold; e.hs = cyc;
            sb.push_back(e);
         end
      end

      drained = 1'b0;
      for (int w = 0; w < 300 && !drained; w++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.rsp_valid && bus.req_ready) drained = 1'b1;
      end
      chk("drain_done", {31'd0, drained}, 32'd1);

      // abort a multiply partway through with reset; its result must never appear
      bus.oprn      = ALU_OP_MUL;
      bus.op1       = 32'd7;
      bus.op2       = 32'd5;
      bus.req_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("abort_out", bus.out, 32'd0);
      chk("abort_zero", {31'd0, bus.zero}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("post_abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("post_abort_out", bus.out, 32'd0);
      chk("post_abort_sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
